// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard controller.
package kbd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_DECODE
    } kbd_state_e;

    localparam logic [7:0]  KBD_EXT_PREFIX = 8'hE0;
    localparam logic [7:0]  KBD_BRK_PREFIX = 8'hF0;
    localparam int unsigned KBD_ENTRY_W    = 10;

endpackage

// File: rtl/kbd_fifo.sv
// First-word-fall-through FIFO for scan events; head reads as zero when empty.
module kbd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, rd_q;
    logic             do_pop, do_push;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a push while full still lands.
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= din_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + (AW+1)'(1);
            if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard receiver: synchronizer, frame FSM, E0/F0 prefix decode, event FIFO.
// Define KBD_TIMEOUT_EN to abort frames whose PS/2 clock stalls for TIMEOUT_CYC cycles.
module ps2_kbd_ctrl
    import kbd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_en,
    input  logic       clr_err,
    output logic [7:0] key_code,
    output logic       key_break,
    output logic       key_ext,
    output logic       key_valid,
    output logic       overflow,
    output logic       frame_err
);

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || TIMEOUT_CYC == 0) begin : g_bad_cfg
        $error("ps2_kbd_ctrl: unsupported FIFO_DEPTH or TIMEOUT_CYC");
    end

    logic       clk_s1_q, clk_s2_q, clk_s3_q;
    logic       dat_s1_q, dat_s2_q;
    logic       fall, dat;

    kbd_state_e state_q;
    logic [7:0] shift_q;
    logic [2:0] bitcnt_q;
    logic       parity_q;
    logic       ext_pend_q, brk_pend_q;
    logic       frame_err_q, overflow_q;

    logic                   push, fifo_full, fifo_empty;
    logic [KBD_ENTRY_W-1:0] fifo_din, fifo_dout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            clk_s3_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            clk_s3_q <= clk_s2_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
        end
    end

    assign fall = clk_s3_q && !clk_s2_q;
    assign dat  = dat_s2_q;

`ifdef KBD_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            bitcnt_q    <= '0;
            parity_q    <= 1'b0;
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef KBD_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
        end else begin
            // Clear first so an error raised below in the same cycle takes priority.
            if (clr_err) frame_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (fall && !dat) begin
                        state_q  <= ST_DATA;
                        bitcnt_q <= '0;
                    end
                end
                ST_DATA: begin
                    if (fall) begin
                        shift_q  <= {dat, shift_q[7:1]};
                        bitcnt_q <= bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) state_q <= ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    if (fall) begin
                        parity_q <= dat;
                        state_q  <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (fall) begin
                        if (dat && (^{shift_q, parity_q})) begin
                            state_q <= ST_DECODE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_IDLE;
                        end
                    end
                end
                ST_DECODE: begin
                    if (shift_q == KBD_EXT_PREFIX) begin
                        ext_pend_q <= 1'b1;
                    end else if (shift_q == KBD_BRK_PREFIX) begin
                        brk_pend_q <= 1'b1;
                    end else begin
                        ext_pend_q <= 1'b0;
                        brk_pend_q <= 1'b0;
                    end
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
`ifdef KBD_TIMEOUT_EN
            // Only fires on non-fall cycles, so it never collides with a case move.
            if (state_q inside {ST_DATA, ST_PARITY, ST_STOP}) begin
                if (fall) begin
                    to_cnt_q <= '0;
                end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    to_cnt_q    <= '0;
                    frame_err_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end else begin
                    to_cnt_q <= to_cnt_q + TO_W'(1);
                end
            end else begin
                to_cnt_q <= '0;
            end
`endif
        end
    end

    assign push = (state_q == ST_DECODE) &&
                  (shift_q != KBD_EXT_PREFIX) && (shift_q != KBD_BRK_PREFIX);
    assign fifo_din = {ext_pend_q, brk_pend_q, shift_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else begin
            if (clr_err) overflow_q <= 1'b0;
            if (push && fifo_full && !rd_en) overflow_q <= 1'b1;
        end
    end

    kbd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (KBD_ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (rd_en),
        .din_i   (fifo_din),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign key_code  = fifo_dout[7:0];
    assign key_break = fifo_dout[8];
    assign key_ext   = fifo_dout[9];
    assign key_valid = !fifo_empty;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl; stall step adapts to KBD_TIMEOUT_EN.
module tb_ps2_kbd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] key_code;
    logic       key_break, key_ext, key_valid, overflow, frame_err;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ps2_kbd_ctrl #(
        .FIFO_DEPTH  (4),
        .TIMEOUT_CYC (200)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rd_en     (rd_en),
        .clr_err   (clr_err),
        .key_code  (key_code),
        .key_break (key_break),
        .key_ext   (key_ext),
        .key_valid (key_valid),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bits 0..10: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] fbits(input logic [7:0] b, input logic badpar,
                                          input logic badstop);
        return {~badstop, (~^b) ^ badpar, b, 1'b0};
    endfunction

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (8) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_range(input logic [10:0] v, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send_bit(v[i]);
    endtask

    task automatic send_frame(input logic [7:0] b);
        send_range(fbits(b, 1'b0, 1'b0), 0, 10);
    endtask

    // Stop bit with rd_en held across the edge on which the decoded byte is pushed.
    task automatic send_stop_pop();
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        #1 rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
        repeat (6) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic pop();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_err();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", key_valid, 0);
        chk("rst_code", key_code, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_ferr", frame_err, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        send_frame(8'h1C);
        chk("mk_valid", key_valid, 1);
        chk("mk_code", key_code, 8'h1C);
        chk("mk_brk", key_break, 0);
        chk("mk_ext", key_ext, 0);
        pop();
        chk("mk_pop_valid", key_valid, 0);
        chk("mk_pop_code", key_code, 0);

        send_frame(8'hF0);
        send_frame(8'h1C);
        chk("brk_code", key_code, 8'h1C);
        chk("brk_brk", key_break, 1);
        chk("brk_ext", key_ext, 0);
        pop();
        chk("brk_single", key_valid, 0);

        send_frame(8'hE0);
        send_frame(8'hF0);
        send_frame(8'h75);
        chk("ext_code", key_code, 8'h75);
        chk("ext_ext", key_ext, 1);
        chk("ext_brk", key_break, 1);
        pop();
        chk("ext_single", key_valid, 0);

        send_range(fbits(8'h1C, 1'b1, 1'b0), 0, 10);
        chk("par_nopush", key_valid, 0);
        chk("par_ferr", frame_err, 1);
        clear_err();
        chk("par_clr", frame_err, 0);
        send_range(fbits(8'h1C, 1'b0, 1'b1), 0, 10);
        chk("stop_nopush", key_valid, 0);
        chk("stop_ferr", frame_err, 1);
        clear_err();

        send_frame(8'h15);
        send_frame(8'h16);
        send_frame(8'h1E);
        send_frame(8'h26);
        chk("full_noovf", overflow, 0);
        send_frame(8'h25);
        chk("ovf_set", overflow, 1);
        chk("ovf_head", key_code, 8'h15);
        chk("ovf_head_brk", key_break, 0);
        clear_err();
        chk("ovf_clr", overflow, 0);
        send_range(fbits(8'h2E, 1'b0, 1'b0), 0, 9);
        send_stop_pop();
        chk("pp_noovf", overflow, 0);
        chk("pp_head", key_code, 8'h16);
        pop();
        chk("pp_e1", key_code, 8'h1E);
        pop();
        chk("pp_e2", key_code, 8'h26);
        pop();
        chk("pp_e3", key_code, 8'h2E);
        chk("pp_e3_valid", key_valid, 1);
        pop();
        chk("pp_empty", key_valid, 0);
        pop();
        send_frame(8'h36);
        chk("empty_rd_code", key_code, 8'h36);
        chk("empty_rd_valid", key_valid, 1);
        pop();
        chk("empty_rd_drain", key_valid, 0);

        send_range(fbits(8'h29, 1'b0, 1'b0), 0, 4);
        repeat (300) @(negedge clk);
`ifdef KBD_TIMEOUT_EN
        chk("to_ferr", frame_err, 1);
        chk("to_nopush", key_valid, 0);
        clear_err();
        send_frame(8'h29);
`else
        chk("stall_noerr", frame_err, 0);
        send_range(fbits(8'h29, 1'b0, 1'b0), 5, 10);
`endif
        chk("after_stall_code", key_code, 8'h29);
        chk("after_stall_valid", key_valid, 1);
        pop();

        send_frame(8'h1C);
        send_range(fbits(8'h1C, 1'b1, 1'b0), 0, 10);
        send_range(fbits(8'h77, 1'b0, 1'b0), 0, 3);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", key_valid, 0);
        chk("mid_rst_code", key_code, 0);
        chk("mid_rst_ferr", frame_err, 0);
        chk("mid_rst_ovf", overflow, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(8'h5A);
        chk("post_rst_code", key_code, 8'h5A);
        chk("post_rst_valid", key_valid, 1);
        chk("post_rst_ferr", frame_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
